// File: rtl/relobi_demux_pkg.sv
// Shared relobi request/response types and the TMR majority voter.
package relobi_demux_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [6:0]  ecc;
    } obi_a_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [6:0]  ecc;
    } obi_r_t;

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] rready;
        obi_a_t     a;
    } obi_req_t;

    typedef struct packed {
        logic [2:0] gnt;
        logic [2:0] rvalid;
        obi_r_t     r;
    } obi_rsp_t;

    localparam int unsigned VoteWidth = 8;

    // Bitwise 2-of-3 majority; callers zero-extend narrower fields.
    function automatic logic [VoteWidth-1:0] vote3(input logic [VoteWidth-1:0] a,
                                                   input logic [VoteWidth-1:0] b,
                                                   input logic [VoteWidth-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/relobi_demux_lane.sv
// One lane of routing state: outstanding counter and port lock, advanced from the voted state.
module relobi_demux_lane #(
    parameter int unsigned NumMaxTrans = 2,
    parameter int unsigned SelWidth    = 2,
    parameter int unsigned CntWidth    = 2,
    parameter bit          UseRReady   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [SelWidth-1:0] select,
    input  logic                req,
    input  logic                gnt,
    input  logic                rvalid,
    input  logic                rready,
    input  logic [CntWidth-1:0] cnt_voted,
    input  logic [SelWidth-1:0] sel_voted,
    output logic                stall,
    output logic [CntWidth-1:0] cnt_q,
    output logic [SelWidth-1:0] sel_q
);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumMaxTrans);

    logic busy;
    logic accept;
    logic retire;

    assign busy   = (cnt_voted != '0);
    assign stall  = (busy && (select != sel_voted)) || (cnt_voted == CntMax);
    assign accept = req & gnt & ~stall;
    // A response with nothing outstanding is ignored so the counter cannot underflow.
    assign retire = rvalid & (rready | ~UseRReady) & busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   cnt_q <= cnt_voted + 1'b1;
                2'b01:   cnt_q <= cnt_voted - 1'b1;
                default: cnt_q <= cnt_voted;
            endcase
            sel_q <= accept ? select : sel_voted;
        end
    end

endmodule

// File: rtl/relobi_demux.sv
// Reliable OBI demultiplexer: one TMR-handshake subordinate port routed to NumMgrPorts managers.
module relobi_demux
    import relobi_demux_pkg::*;
#(
    parameter int unsigned NumMgrPorts = 4,
    parameter int unsigned NumMaxTrans = 2,
    parameter bit          UseRReady   = 1'b1,
    parameter int unsigned SelWidth    = $clog2(NumMgrPorts)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  obi_req_t                      sbr_port_req_i,
    output obi_rsp_t                      sbr_port_rsp_o,
    input  logic [2:0][SelWidth-1:0]      sbr_port_select_i,
    output obi_req_t [NumMgrPorts-1:0]    mgr_ports_req_o,
    input  obi_rsp_t [NumMgrPorts-1:0]    mgr_ports_rsp_i,
    output logic [1:0]                    fault_o
);
    localparam int unsigned CntWidth = $clog2(NumMaxTrans + 1);

    logic [CntWidth-1:0] cnt_q [3];
    logic [SelWidth-1:0] sel_q [3];
    logic [CntWidth-1:0] cnt_v;
    logic [SelWidth-1:0] sel_v;
    logic [2:0]          stall;
    logic [2:0]          gnt_sel;
    logic [2:0]          rvalid_sel;
    logic [2:0]          rvalid_any;
    logic                state_mismatch;

    assign cnt_v = CntWidth'(vote3(VoteWidth'(cnt_q[0]), VoteWidth'(cnt_q[1]), VoteWidth'(cnt_q[2])));
    assign sel_v = SelWidth'(vote3(VoteWidth'(sel_q[0]), VoteWidth'(sel_q[1]), VoteWidth'(sel_q[2])));

    for (genvar l = 0; l < 3; l++) begin : g_lane
        relobi_demux_lane #(
            .NumMaxTrans (NumMaxTrans),
            .SelWidth    (SelWidth),
            .CntWidth    (CntWidth),
            .UseRReady   (UseRReady)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .select    (sbr_port_select_i[l]),
            .req       (sbr_port_req_i.req[l]),
            .gnt       (gnt_sel[l]),
            .rvalid    (rvalid_sel[l]),
            .rready    (sbr_port_req_i.rready[l]),
            .cnt_voted (cnt_v),
            .sel_voted (sel_v),
            .stall     (stall[l]),
            .cnt_q     (cnt_q[l]),
            .sel_q     (sel_q[l])
        );
    end

    // Grant is taken from the port each lane requests; responses from the voted lock.
    always_comb begin
        gnt_sel    = '0;
        rvalid_sel = '0;
        rvalid_any = '0;
        for (int l = 0; l < 3; l++) begin
            if (32'(sbr_port_select_i[l]) < NumMgrPorts)
                gnt_sel[l] = mgr_ports_rsp_i[sbr_port_select_i[l]].gnt[l];
            if (32'(sel_v) < NumMgrPorts)
                rvalid_sel[l] = mgr_ports_rsp_i[sel_v].rvalid[l];
            for (int p = 0; p < NumMgrPorts; p++)
                rvalid_any[l] = rvalid_any[l] | mgr_ports_rsp_i[p].rvalid[l];
        end
    end

    always_comb begin
        for (int p = 0; p < NumMgrPorts; p++) begin
            mgr_ports_req_o[p].a = sbr_port_req_i.a;
            for (int l = 0; l < 3; l++) begin
                mgr_ports_req_o[p].req[l]    = sbr_port_req_i.req[l] & ~stall[l] &
                                               (32'(sbr_port_select_i[l]) == p);
                mgr_ports_req_o[p].rready[l] = sbr_port_req_i.rready[l] & (32'(sel_v) == p);
            end
        end
    end

    always_comb begin
        sbr_port_rsp_o.gnt    = gnt_sel & ~stall;
        sbr_port_rsp_o.rvalid = rvalid_sel & {3{cnt_v != '0}};
        sbr_port_rsp_o.r      = '0;
        if (32'(sel_v) < NumMgrPorts)
            sbr_port_rsp_o.r = mgr_ports_rsp_i[sel_v].r;
    end

    assign state_mismatch = (cnt_q[0] != cnt_q[1]) || (cnt_q[1] != cnt_q[2]) ||
                            (sel_q[0] != sel_q[1]) || (sel_q[1] != sel_q[2]);

    assign fault_o[0] = state_mismatch || ((cnt_v == '0) && (|rvalid_any));
    assign fault_o[1] = (|sbr_port_req_i.req) &&
                        ((sbr_port_select_i[0] != sbr_port_select_i[1]) ||
                         (sbr_port_select_i[1] != sbr_port_select_i[2]));

endmodule

// File: tb/tb_relobi_demux.sv
// Directed bench for relobi_demux with 4 manager ports and 2 outstanding transactions.
module tb_relobi_demux;
    import relobi_demux_pkg::*;

    localparam int unsigned NP = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    obi_req_t            sbr_req;
    obi_rsp_t            sbr_rsp;
    logic [2:0][1:0]     sel;
    obi_req_t [NP-1:0]   mgr_req;
    obi_rsp_t [NP-1:0]   mgr_rsp;
    logic [1:0]          fault;

    int n_pass  = 0;
    int n_total = 0;

    relobi_demux #(.NumMgrPorts(NP), .NumMaxTrans(2), .UseRReady(1'b1)) u_dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .sbr_port_req_i    (sbr_req),
        .sbr_port_rsp_o    (sbr_rsp),
        .sbr_port_select_i (sel),
        .mgr_ports_req_o   (mgr_req),
        .mgr_ports_rsp_i   (mgr_rsp),
        .fault_o           (fault)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0]  sel;
        logic [2:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic [11:0] e_mreq;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic [1:0]  e_flt;
        int          e_rport;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [5:0] s, input logic [2:0] req, input logic [3:0] gnt,
                         input logic [3:0] rv);
        for (int l = 0; l < 3; l++) sel[l] = s[2*l +: 2];
        sbr_req.req    = req;
        sbr_req.rready = 3'b111;
        for (int p = 0; p < NP; p++) begin
            mgr_rsp[p].gnt    = {3{gnt[p]}};
            mgr_rsp[p].rvalid = {3{rv[p]}};
        end
    endtask

    function automatic logic [11:0] mreq_flat();
        logic [11:0] v;
        for (int p = 0; p < NP; p++) v[3*p +: 3] = mgr_req[p].req;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        sbr_req = '0;
        sbr_req.a.addr = 32'h1234_5678;
        sel = '0;
        mgr_rsp = '0;
        for (int p = 0; p < NP; p++) mgr_rsp[p].r.rdata = 32'hA000_0000 + p;

        //            sel        req     gnt      rv       mreq     gnt     rv      flt    rport
        vecs[0]  = '{6'b000000, 3'b000, 4'b0000, 4'b0000, 12'h000, 3'b000, 3'b000, 2'b00, 0};
        vecs[1]  = '{6'b101010, 3'b111, 4'b0100, 4'b0000, 12'h1C0, 3'b111, 3'b000, 2'b00, 0};
        vecs[2]  = '{6'b101010, 3'b000, 4'b0000, 4'b0100, 12'h000, 3'b000, 3'b111, 2'b00, 2};
        vecs[3]  = '{6'b010101, 3'b111, 4'b0010, 4'b0000, 12'h038, 3'b111, 3'b000, 2'b00, 0};
        vecs[4]  = '{6'b010101, 3'b111, 4'b0010, 4'b0000, 12'h038, 3'b111, 3'b000, 2'b00, 0};
        vecs[5]  = '{6'b010101, 3'b111, 4'b0010, 4'b0000, 12'h000, 3'b000, 3'b000, 2'b00, 0};
        vecs[6]  = '{6'b010101, 3'b111, 4'b0010, 4'b0010, 12'h000, 3'b000, 3'b111, 2'b00, 1};
        vecs[7]  = '{6'b010101, 3'b111, 4'b0010, 4'b0010, 12'h038, 3'b111, 3'b111, 2'b00, 1};
        vecs[8]  = '{6'b111111, 3'b111, 4'b1000, 4'b0000, 12'h000, 3'b000, 3'b000, 2'b00, 0};
        vecs[9]  = '{6'b111111, 3'b111, 4'b1000, 4'b0010, 12'h000, 3'b000, 3'b111, 2'b00, 1};
        vecs[10] = '{6'b111111, 3'b111, 4'b1000, 4'b0000, 12'hE00, 3'b111, 3'b000, 2'b00, 0};
        vecs[11] = '{6'b111111, 3'b000, 4'b0000, 4'b1000, 12'h000, 3'b000, 3'b111, 2'b00, 3};
        vecs[12] = '{6'b000000, 3'b000, 4'b0000, 4'b0100, 12'h000, 3'b000, 3'b000, 2'b01, 0};
        vecs[13] = '{6'b000101, 3'b111, 4'b0011, 4'b0000, 12'h01C, 3'b111, 3'b000, 2'b10, 0};
        vecs[14] = '{6'b010101, 3'b000, 4'b0000, 4'b0010, 12'h000, 3'b000, 3'b111, 2'b01, 1};
        vecs[15] = '{6'b010101, 3'b000, 4'b0000, 4'b0000, 12'h000, 3'b000, 3'b000, 2'b00, 0};

        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].sel, vecs[i].req, vecs[i].gnt, vecs[i].rv);
            #3;
            chk($sformatf("v%0d_mreq", i), 32'(mreq_flat()), 32'(vecs[i].e_mreq));
            chk($sformatf("v%0d_gnt", i), 32'(sbr_rsp.gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_rvalid", i), 32'(sbr_rsp.rvalid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].e_flt));
            if (vecs[i].e_rv != 3'b000)
                chk($sformatf("v%0d_rdata", i), sbr_rsp.r.rdata, 32'hA000_0000 + vecs[i].e_rport);
            @(posedge clk_i); #1;
        end
        chk("a_broadcast", mgr_req[3].a.addr, 32'h1234_5678);

        // Corrupt one lane's counter: voted state masks it, then scrubbing repairs it.
        drive(6'b101010, 3'b111, 4'b0100, 4'b0000);
        @(posedge clk_i); #1;
        drive(6'b101010, 3'b000, 4'b0000, 4'b0000);
        force u_dut.g_lane[1].u_lane.cnt_q = 2'd2;
        #3;
        chk("force_fault", 32'(fault), 32'h1);
        release u_dut.g_lane[1].u_lane.cnt_q;
        @(posedge clk_i); #1;
        chk("scrub_fault", 32'(fault), 32'h0);
        chk("scrub_lane1", 32'(u_dut.g_lane[1].u_lane.cnt_q), 32'h1);
        drive(6'b101010, 3'b000, 4'b0000, 4'b0100);
        #3;
        chk("scrub_rvalid", 32'(sbr_rsp.rvalid), 32'h7);
        @(posedge clk_i); #1;

        // Reset with one transaction outstanding; the late response must be dropped.
        drive(6'b010101, 3'b111, 4'b0010, 4'b0000);
        #3;
        chk("pre_rst_gnt", 32'(sbr_rsp.gnt), 32'h7);
        @(posedge clk_i); #1;
        drive(6'b010101, 3'b000, 4'b0000, 4'b0000);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        drive(6'b010101, 3'b000, 4'b0000, 4'b0010);
        #3;
        chk("late_rvalid", 32'(sbr_rsp.rvalid), 32'h0);
        chk("late_fault", 32'(fault), 32'h1);
        @(posedge clk_i); #1;
        drive(6'b000000, 3'b000, 4'b0000, 4'b0000);
        #3;
        chk("late_cnt", 32'(u_dut.g_lane[0].u_lane.cnt_q), 32'h0);
        chk("late_idle_fault", 32'(fault), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
